// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_responder
//  Description : Emulates an asynchronous SRAM chip behind its pin interface
//                using on-chip RAM, and counts write and read transactions.
//                Optional protocol checker: SRAM_RESPONDER_VIOLATION_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

module sram_responder #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 16,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_BITS-1:0]  addr_bus,
    inout  wire  [DATA_BITS-1:0]  data_bus,
    input  logic                  we_n,
    input  logic                  oe_n,
    input  logic                  ce_n,
    output logic [COUNT_BITS-1:0] write_count,
    output logic [COUNT_BITS-1:0] read_count,
    output logic                  drive_en,
    output logic                  violation
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t                 state_q, state_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   ce_n_q, ce_n_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [ADDR_BITS-1:0]   addr_prev_q, addr_prev_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]   wr_data_q, wr_data_d;
    logic [COUNT_BITS-1:0]  write_count_q, write_count_d;
    logic [COUNT_BITS-1:0]  read_count_q, read_count_d;
    logic                   drive_en_q, drive_en_d;
    logic [DATA_BITS-1:0]   rd_data_q;
    logic                   commit;
    logic                   rd_inc;
    logic                   addr_changed;

    logic [DATA_BITS-1:0]   mem [0:DEPTH-1];

    assign addr_changed = (addr_q != addr_prev_q);

    always_comb begin
        state_d       = state_q;
        we_n_d        = we_n;
        oe_n_d        = oe_n;
        ce_n_d        = ce_n;
        addr_d        = addr_bus;
        data_d        = data_bus;
        addr_prev_d   = addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        commit        = 1'b0;
        rd_inc        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!ce_n_q && !we_n_q) begin
                    state_d = ST_WRITE;
                end else if (!ce_n_q && !oe_n_q) begin
                    state_d = ST_READ;
                    rd_inc  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (we_n_q || ce_n_q) begin
                    state_d = ST_IDLE;
                    commit  = 1'b1;
                end
            end
            ST_READ: begin
                // A write request wins over an ongoing read and releases the bus.
                if (ce_n_q) begin
                    state_d = ST_IDLE;
                end else if (!we_n_q) begin
                    state_d = ST_WRITE;
                end else if (oe_n_q) begin
                    state_d = ST_IDLE;
                end else if (addr_changed) begin
                    rd_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Track the latest sample taken while the write strobe is low.
        if (state_d == ST_WRITE) begin
            wr_addr_d = addr_q;
            wr_data_d = data_q;
        end

        write_count_d = write_count_q + {{(COUNT_BITS-1){1'b0}}, commit};
        read_count_d  = read_count_q + {{(COUNT_BITS-1){1'b0}}, rd_inc};
        drive_en_d    = (state_q == ST_READ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            we_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            ce_n_q        <= 1'b1;
            addr_q        <= '0;
            addr_prev_q   <= '0;
            data_q        <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            write_count_q <= '0;
            read_count_q  <= '0;
            drive_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_n_q        <= we_n_d;
            oe_n_q        <= oe_n_d;
            ce_n_q        <= ce_n_d;
            addr_q        <= addr_d;
            addr_prev_q   <= addr_prev_d;
            data_q        <= data_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            drive_en_q    <= drive_en_d;
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_addr_q] <= wr_data_q;
        end
        rd_data_q <= mem[addr_q];
    end

    assign data_bus    = drive_en_q ? rd_data_q : {DATA_BITS{1'bz}};
    assign drive_en    = drive_en_q;
    assign write_count = write_count_q;
    assign read_count  = read_count_q;

`ifdef SRAM_RESPONDER_VIOLATION_EN
    logic violation_q, violation_d;
    logic viol_we_oe;
    logic viol_addr;
    logic viol_contend;

    always_comb begin
        viol_we_oe   = !ce_n_q && !we_n_q && !oe_n_q;
        viol_addr    = (state_q == ST_WRITE) && addr_changed;
        viol_contend = drive_en_q && !ce_n_q && !oe_n_q && !we_n_q;
        violation_d  = violation_q || viol_we_oe || viol_addr || viol_contend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            violation_q <= 1'b0;
        end else begin
            violation_q <= violation_d;
        end
    end

    assign violation = violation_q;
`else
    assign violation = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_responder
//  Description : Scoreboard bench for sram_responder; read data is queued at
//                stimulus time and checked by a forked bus monitor.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_sram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr = 8'h00;
    logic        we_n = 1'b1;
    logic        oe_n = 1'b1;
    logic        ce_n = 1'b1;
    logic        drv = 1'b0;
    logic [15:0] data_drv = 16'h0000;
    logic        we2_n = 1'b1;
    logic        mon_skip = 1'b0;

    wire  [15:0] data_bus;
    wire  [15:0] write_count;
    wire  [15:0] read_count;
    wire         drive_en;
    wire         violation;

    wire  [15:0] bus2;
    wire  [3:0]  wc2;
    wire  [3:0]  rc2;
    wire         de2;
    wire         vi2;

    int          n_checks = 0;
    int          n_fails = 0;
    logic [15:0] exp_q [$];
    int          rc_base;
    int          exp_viol;

    always #5 clk = ~clk;

    assign data_bus = drv ? data_drv : 16'hzzzz;
    assign bus2     = !we2_n ? 16'h0F0F : 16'hzzzz;

    sram_responder #(
        .ADDR_BITS  (8),
        .DATA_BITS  (16),
        .COUNT_BITS (16)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .addr_bus    (addr),
        .data_bus    (data_bus),
        .we_n        (we_n),
        .oe_n        (oe_n),
        .ce_n        (ce_n),
        .write_count (write_count),
        .read_count  (read_count),
        .drive_en    (drive_en),
        .violation   (violation)
    );

    sram_responder #(
        .ADDR_BITS  (8),
        .DATA_BITS  (16),
        .COUNT_BITS (4)
    ) u_dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .addr_bus    (8'h07),
        .data_bus    (bus2),
        .we_n        (we2_n),
        .oe_n        (1'b1),
        .ce_n        (1'b0),
        .write_count (wc2),
        .read_count  (rc2),
        .drive_en    (de2),
        .violation   (vi2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One queued word per cycle the responder is expected to drive the bus.
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!reset && !mon_skip && drive_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL bus_unexpected_drive: got drive_en=1 data=0x%0h, expected no drive", data_bus);
                end else begin
                    e = exp_q.pop_front();
                    if (data_bus !== e) begin
                        n_fails++;
                        $display("FAIL bus_read_data: got 0x%0h, expected 0x%0h", data_bus, e);
                    end
                end
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input int h);
        addr     = a;
        data_drv = d;
        drv      = 1'b1;
        we_n     = 1'b0;
        tick(h);
        we_n     = 1'b1;
        drv      = 1'b0;
        tick(3);
    endtask

    task automatic rd(input logic [7:0] a, input int h, input logic [15:0] e);
        for (int k = 0; k < h; k++) exp_q.push_back(e);
        addr = a;
        oe_n = 1'b0;
        tick(h);
        oe_n = 1'b1;
        tick(3);
        chk("read_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        fork
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        tick(3);
        chk("rst_drive_en", drive_en, 0);
        chk("rst_write_count", write_count, 0);
        chk("rst_read_count", read_count, 0);
        chk("rst_violation", violation, 0);
        ce_n  = 1'b0;
        reset = 1'b0;
        tick(2);

        // Write then read with 3-cycle latency
        wr(8'h12, 16'hA5A5, 2);
        rd(8'h12, 1, 16'hA5A5);
        chk("t1_write_count", write_count, 1);
        chk("t1_read_count", read_count, 1);

        // Full sweep
        do_reset();
        for (int i = 0; i < 256; i++) wr(8'(i), 16'(i), 1);
        for (int i = 0; i < 256; i++) rd(8'(i), 1, 16'(i));
        chk("t2_write_count", write_count, 256);
        chk("t2_read_count", read_count, 256);
        chk("t2_violation", violation, 0);

        // Address hop inside one read
        rc_base = read_count;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0001);
        for (int k = 0; k < 4; k++) exp_q.push_back(16'h0002);
        addr = 8'h01;
        oe_n = 1'b0;
        tick(3);
        addr = 8'h02;
        tick(3);
        oe_n = 1'b1;
        tick(3);
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_read_delta", read_count - rc_base, 2);

        // Simultaneous we_n/oe_n is a write; never driven
        addr     = 8'h30;
        data_drv = 16'h1234;
        drv      = 1'b1;
        we_n     = 1'b0;
        oe_n     = 1'b0;
        tick(2);
        we_n     = 1'b1;
        oe_n     = 1'b1;
        drv      = 1'b0;
        tick(3);
`ifdef SRAM_RESPONDER_VIOLATION_EN
        exp_viol = 1;
`else
        exp_viol = 0;
`endif
        chk("t4_violation", violation, exp_viol);
        chk("t4_drive_en", drive_en, 0);
        rd(8'h30, 1, 16'h1234);
        do_reset();
        chk("t4_violation_cleared", violation, 0);

        // Reset while driving releases the bus immediately
        mon_skip = 1'b1;
        addr     = 8'h12;
        oe_n     = 1'b0;
        tick(4);
        chk("rr_drive_before", drive_en, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("rr_drive_after", drive_en, 0);
        chk("rr_read_count", read_count, 0);
        oe_n = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        mon_skip = 1'b0;

        // Reset mid-write discards the write
        wr(8'h40, 16'h5555, 1);
        addr     = 8'h40;
        data_drv = 16'hDEAD;
        drv      = 1'b1;
        we_n     = 1'b0;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_drive_en", drive_en, 0);
        chk("t5_write_count", write_count, 0);
        chk("t5_read_count", read_count, 0);
        we_n = 1'b1;
        drv  = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        rd(8'h40, 2, 16'h5555);
        chk("t5_write_count_after", write_count, 0);
        chk("t5_read_count_after", read_count, 1);

        // 4-bit counter wrap
        for (int i = 0; i < 16; i++) begin
            we2_n = 1'b0;
            tick(1);
            we2_n = 1'b1;
            tick(2);
        end
        chk("t6_wrap_16", wc2, 0);
        we2_n = 1'b0;
        tick(1);
        we2_n = 1'b1;
        tick(2);
        chk("t6_wrap_17", wc2, 1);
        chk("t6_read_count", rc2, 0);
        chk("t6_drive_en", de2, 0);
        chk("t6_violation", vi2, 0);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
